// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Purpose : Shared state encoding and stage write-enable patterns for the
//           pipeline stall controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_STALL = 3'd1,
    ST_MISS_I     = 3'd2,
    ST_MISS_D     = 3'd3,
    ST_MISS_BOTH  = 3'd4,
    ST_DMA_GRANT  = 3'd5,
    ST_HALT       = 3'd6
  } state_t;

  // Bit positions inside stage_we = {PC, ID, EX, M, WB}
  localparam int WE_PC = 4;
  localparam int WE_ID = 3;
  localparam int WE_EX = 2;
  localparam int WE_M  = 1;
  localparam int WE_WB = 0;

  localparam logic [4:0] WE_NONE  = 5'b00000;
  localparam logic [4:0] WE_MEMWB = (5'b1 << WE_M) | (5'b1 << WE_WB);
  localparam logic [4:0] WE_DRAIN = WE_MEMWB | (5'b1 << WE_EX);
  localparam logic [4:0] WE_ALL   = WE_DRAIN | (5'b1 << WE_ID) | (5'b1 << WE_PC);

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_fwd_select.sv
// ============================================================================
// Module  : fwd_select
// Purpose : Priority match of one ID source register against the destination
//           registers of the forwarding stages; the youngest stage wins.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_select #(
  parameter int REG_AW  = 2,
  parameter int NUM_FWD = 3,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                      i_use,
  input  logic [REG_AW-1:0]         i_src,
  input  logic [NUM_FWD*REG_AW-1:0] i_dest,
  input  logic [NUM_FWD-1:0]        i_regwrite,
  output logic [SEL_W-1:0]          o_sel
);

  // Scan oldest to youngest so the lowest matching stage overwrites last
  always_comb begin
    o_sel = '0;
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (i_use && i_regwrite[k-1] && (i_dest[(k-1)*REG_AW +: REG_AW] == i_src)) begin
        o_sel = SEL_W'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// Module  : pipe_stall_ctrl
// Purpose : Pipeline stall/forward controller: operand forwarding, load-use
//           bubble, I/D cache miss freeze, DMA bus grant and halt drain.
//           Macro PIPE_STALL_CTRL_DMA_EN enables the DMA bus-grant path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 2,
  parameter int NUM_FWD = 3,
  parameter int DMA_LEN = 12
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [REG_AW-1:0]              rs_id,
  input  logic [REG_AW-1:0]              rt_id,
  input  logic                           use_rs,
  input  logic                           use_rt,
  input  logic [NUM_FWD*REG_AW-1:0]      dest,
  input  logic [NUM_FWD-1:0]             regwrite,
  input  logic                           load_ex,
  input  logic                           halt_id,
  input  logic                           i_miss,
  input  logic                           d_miss,
  input  logic                           i_ready,
  input  logic                           d_ready,
  input  logic                           br,
  output logic                           bg,
  output logic [4:0]                     stage_we,
  output logic                           flush_ex,
  output logic [$clog2(NUM_FWD+1)-1:0]   fwd_a,
  output logic [$clog2(NUM_FWD+1)-1:0]   fwd_b,
  output logic                           both_access,
  output logic                           halted,
  output logic [2:0]                     state
);

  localparam int SEL_W = $clog2(NUM_FWD + 1);

  state_t       r_state;
  state_t       w_next;
  state_t       w_view;
  logic [7:0]   r_cnt;
  logic         r_i_done;
  logic         r_d_done;
  logic         r_halted;
  logic         w_hazard;
  logic         w_br;
  logic         w_both_done;
  logic [4:0]   w_we;
  logic         w_flush;
  logic         w_both;

  fwd_select #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_a (
    .i_use      (use_rs),
    .i_src      (rs_id),
    .i_dest     (dest),
    .i_regwrite (regwrite),
    .o_sel      (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_b (
    .i_use      (use_rt),
    .i_src      (rt_id),
    .i_dest     (dest),
    .i_regwrite (regwrite),
    .o_sel      (fwd_b)
  );

  assign w_hazard    = load_ex && ((fwd_a == SEL_W'(1)) || (fwd_b == SEL_W'(1)));
  assign w_both_done = (r_i_done || i_ready) && (r_d_done || d_ready);

`ifdef PIPE_STALL_CTRL_DMA_EN
  logic r_bg;

  assign w_br = br;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bg <= 1'b0;
    end else begin
      r_bg <= (w_next == ST_DMA_GRANT);
    end
  end

  assign bg = r_bg;
`else
  logic w_unused_br;

  assign w_unused_br = br;
  assign w_br        = 1'b0;
  assign bg          = 1'b0;
`endif

  // Only IDLE consults br, so a request raised during a miss waits there
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (d_miss)        w_next = ST_MISS_D;
        else if (w_hazard) w_next = ST_LOAD_STALL;
        else if (i_miss)   w_next = ST_MISS_I;
        else if (w_br)     w_next = ST_DMA_GRANT;
        else if (halt_id)  w_next = ST_HALT;
      end
      ST_LOAD_STALL: w_next = d_miss ? ST_MISS_D : ST_IDLE;
      ST_MISS_I: begin
        if (d_miss)       w_next = i_ready ? ST_MISS_D : ST_MISS_BOTH;
        else if (i_ready) w_next = ST_IDLE;
      end
      ST_MISS_D: begin
        if (i_miss)       w_next = d_ready ? ST_MISS_I : ST_MISS_BOTH;
        else if (d_ready) w_next = ST_IDLE;
      end
      ST_MISS_BOTH: begin
        if (w_both_done) w_next = ST_IDLE;
      end
      ST_DMA_GRANT: begin
        if (!w_br || (r_cnt == 8'(DMA_LEN - 1))) begin
          if (d_miss)      w_next = ST_MISS_D;
          else if (i_miss) w_next = ST_MISS_I;
          else             w_next = ST_IDLE;
        end
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  // IDLE shows the entered state's enables at once; the registered
  // LOAD_STALL cycle only tracks the load into MEM, the bubble is already in.
  always_comb begin
    w_view  = (r_state == ST_IDLE) ? w_next : r_state;
    w_we    = WE_ALL;
    w_flush = 1'b0;
    w_both  = 1'b0;
    case (w_view)
      ST_LOAD_STALL: begin
        if (r_state == ST_IDLE) begin
          w_we    = WE_MEMWB;
          w_flush = 1'b1;
        end else if (d_miss) begin
          w_we = WE_NONE;
        end
      end
      ST_MISS_I: begin
        w_we    = WE_DRAIN;
        w_flush = 1'b1;
      end
      ST_MISS_D:    w_we = WE_NONE;
      ST_MISS_BOTH: begin
        w_we   = WE_NONE;
        w_both = 1'b1;
      end
      ST_DMA_GRANT: begin
        if (i_miss || d_miss) w_we = WE_NONE;
      end
      ST_HALT: w_we = WE_DRAIN;
      default: ;
    endcase
    if (!reset_n) begin
      w_we    = WE_ALL;
      w_flush = 1'b0;
      w_both  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next;

      if ((w_next == r_state) && ((r_state == ST_DMA_GRANT) || (r_state == ST_HALT))) begin
        r_cnt <= (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
      end else begin
        r_cnt <= 8'd0;
      end

      if ((r_state == ST_MISS_BOTH) && (w_next == ST_MISS_BOTH)) begin
        r_i_done <= r_i_done | i_ready;
        r_d_done <= r_d_done | d_ready;
      end else begin
        r_i_done <= 1'b0;
        r_d_done <= 1'b0;
      end

      if ((r_state == ST_HALT) && (r_cnt >= 8'(NUM_FWD))) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign stage_we    = w_we;
  assign flush_ex    = w_flush;
  assign both_access = w_both;
  assign halted      = r_halted;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// Module  : tb_pipe_stall_ctrl
// Purpose : Self-checking bench for pipe_stall_ctrl (directed scenarios plus a
//           randomized run against a behavioural reference).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int AW = 2;
  localparam int NF = 3;
  localparam int DL = 12;
  localparam int SW = $clog2(NF + 1);
`ifdef PIPE_STALL_CTRL_DMA_EN
  localparam bit DMA_ON = 1'b1;
`else
  localparam bit DMA_ON = 1'b0;
`endif

  localparam int M_IDLE = 0, M_LS = 1, M_MI = 2, M_MD = 3, M_MB = 4, M_DG = 5, M_HT = 6;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [AW-1:0]     rs_id, rt_id;
  logic              use_rs, use_rt;
  logic [NF*AW-1:0]  dest;
  logic [NF-1:0]     regwrite;
  logic              load_ex, halt_id, i_miss, d_miss, i_ready, d_ready, br;
  logic              bg, flush_ex, both_access, halted;
  logic [4:0]        stage_we;
  logic [SW-1:0]     fwd_a, fwd_b;
  logic [2:0]        state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.REG_AW(AW), .NUM_FWD(NF), .DMA_LEN(DL)) dut (
    .clk(clk), .reset_n(reset_n), .rs_id(rs_id), .rt_id(rt_id), .use_rs(use_rs),
    .use_rt(use_rt), .dest(dest), .regwrite(regwrite), .load_ex(load_ex),
    .halt_id(halt_id), .i_miss(i_miss), .d_miss(d_miss), .i_ready(i_ready),
    .d_ready(d_ready), .br(br), .bg(bg), .stage_we(stage_we), .flush_ex(flush_ex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .both_access(both_access), .halted(halted),
    .state(state)
  );

  task automatic clear_inputs();
    rs_id = '0; rt_id = '0; use_rs = 0; use_rt = 0; dest = '0; regwrite = '0;
    load_ex = 0; halt_id = 0; i_miss = 0; d_miss = 0; i_ready = 0; d_ready = 0; br = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Smallest stage number whose write targets src, 0 when none does
  function automatic int ref_fwd(logic u, logic [AW-1:0] src, logic [NF*AW-1:0] d, logic [NF-1:0] rw);
    int sel = 0;
    for (int k = 1; k <= NF; k++) begin
      if (sel == 0 && u && rw[k-1] && d[(k-1)*AW +: AW] == src) sel = k;
    end
    return sel;
  endfunction

  function automatic logic [2:0] mode_code(int m);
    case (m)
      M_LS:    return 3'(ST_LOAD_STALL);
      M_MI:    return 3'(ST_MISS_I);
      M_MD:    return 3'(ST_MISS_D);
      M_MB:    return 3'(ST_MISS_BOTH);
      M_DG:    return 3'(ST_DMA_GRANT);
      M_HT:    return 3'(ST_HALT);
      default: return 3'(ST_IDLE);
    endcase
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    d_miss = 1; br = 1; halt_id = 1; load_ex = 1;
    tick(); tick(); #2;
    total++;
    if ({state, stage_we, flush_ex, both_access, bg, halted} !== {3'(ST_IDLE), 5'b11111, 4'b0000}) begin
      bad++;
      $display("FAIL reset_hold got={st=%0d we=%b fl=%b ba=%b bg=%b h=%b} want={0 11111 0 0 0 0}",
               state, stage_we, flush_ex, both_access, bg, halted);
    end
    clear_inputs();
    tick();
    reset_n = 1'b1;
    #2;
    total++;
    if ({state, stage_we} !== {3'(ST_IDLE), 5'b11111}) begin
      bad++;
      $display("FAIL reset_release got={st=%0d we=%b} want={0 11111}", state, stage_we);
    end
    tick();
  endtask

  task automatic test_fwd_directed();
    clear_inputs();
    rs_id = 2'd2; use_rs = 1; dest = {2'd0, 2'd2, 2'd2}; regwrite = 3'b011;
    #1; total++;
    if (fwd_a !== SW'(1)) begin bad++; $display("FAIL fwd_two_match got=%0d want=1", fwd_a); end
    regwrite = 3'b010;
    #1; total++;
    if (fwd_a !== SW'(2)) begin bad++; $display("FAIL fwd_stage2 got=%0d want=2", fwd_a); end
    use_rs = 0;
    #1; total++;
    if (fwd_a !== SW'(0)) begin bad++; $display("FAIL fwd_no_use got=%0d want=0", fwd_a); end
    rt_id = 2'd3; use_rt = 1; dest = {2'd3, 2'd1, 2'd3}; regwrite = 3'b100;
    #1; total++;
    if (fwd_b !== SW'(3)) begin bad++; $display("FAIL fwd_last_stage got=%0d want=3", fwd_b); end
    regwrite = 3'b000;
    #1; total++;
    if (fwd_b !== SW'(0)) begin bad++; $display("FAIL fwd_no_write got=%0d want=0", fwd_b); end
    clear_inputs();
    tick();
  endtask

  task automatic test_fwd_random();
    int ea, eb;
    for (int i = 0; i < 40; i++) begin
      rs_id = AW'($urandom); rt_id = AW'($urandom);
      use_rs = 1'($urandom); use_rt = 1'($urandom);
      dest = (NF*AW)'($urandom); regwrite = NF'($urandom);
      #1;
      ea = ref_fwd(use_rs, rs_id, dest, regwrite);
      eb = ref_fwd(use_rt, rt_id, dest, regwrite);
      total++;
      if ({fwd_a, fwd_b} !== {SW'(ea), SW'(eb)}) begin
        bad++;
        $display("FAIL fwd_rand got=%0d/%0d want=%0d/%0d", fwd_a, fwd_b, ea, eb);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    rs_id = 2'd1; use_rs = 1; dest = {2'd0, 2'd1, 2'd0}; regwrite = 3'b010; load_ex = 1;
    #2; total++;
    if ({stage_we, flush_ex} !== {5'b11111, 1'b0}) begin
      bad++; $display("FAIL load_no_hazard got=%b/%b want=11111/0", stage_we, flush_ex);
    end
    tick();
    rs_id = 2'd0; use_rs = 0; rt_id = 2'd1; use_rt = 1; dest = {2'd0, 2'd0, 2'd1}; regwrite = 3'b001;
    #2; total++;
    if ({stage_we, flush_ex} !== {5'b00011, 1'b1}) begin
      bad++; $display("FAIL load_stall got=%b/%b want=00011/1", stage_we, flush_ex);
    end
    tick();
    clear_inputs();
    #2; total++;
    if ({stage_we, flush_ex} !== {5'b11111, 1'b0}) begin
      bad++; $display("FAIL load_after1 got=%b/%b want=11111/0", stage_we, flush_ex);
    end
    tick();
    #2; total++;
    if ({state, stage_we} !== {3'(ST_IDLE), 5'b11111}) begin
      bad++; $display("FAIL load_after2 got=%0d/%b want=0/11111", state, stage_we);
    end
    tick();
  endtask

  task automatic test_dual_miss();
    logic [2:0] est;
    clear_inputs();
    i_miss = 1;
    #2; total++;
    if ({stage_we, flush_ex} !== {5'b00111, 1'b1}) begin
      bad++; $display("FAIL imiss_entry got=%b/%b want=00111/1", stage_we, flush_ex);
    end
    for (int t = 1; t <= 7; t++) begin
      tick();
      d_miss  = (t < 6);
      i_miss  = (t < 3);
      i_ready = (t == 3);
      d_ready = (t == 6);
      #2;
      est = (t == 1) ? 3'(ST_MISS_I) : (t == 7) ? 3'(ST_IDLE) : 3'(ST_MISS_BOTH);
      total++;
      if (state !== est) begin bad++; $display("FAIL dual_state t+%0d got=%0d want=%0d", t, state, est); end
      if (t >= 2) begin
        total++;
        if (both_access !== (t < 7)) begin
          bad++; $display("FAIL dual_both t+%0d got=%b want=%b", t, both_access, (t < 7));
        end
      end
    end
    tick();
  endtask

  task automatic test_dma();
    logic ebg;
    clear_inputs();
`ifdef PIPE_STALL_CTRL_DMA_EN
    for (int i = 0; i <= 22; i++) begin
      br = (i < 20);
      #2;
      ebg = (i >= 1 && i <= DL) || (i >= DL + 2 && i <= 20);
      total++;
      if (bg !== ebg) begin bad++; $display("FAIL dma_len i=%0d got=%b want=%b", i, bg, ebg); end
      tick();
    end
    br = 1;
    tick();
    tick();
    d_miss = 1;
    #2; total++;
    if ({state, bg, stage_we} !== {3'(ST_DMA_GRANT), 1'b1, 5'b00000}) begin
      bad++; $display("FAIL dma_miss got=%0d/%b/%b want=5/1/00000", state, bg, stage_we);
    end
    tick();
    br = 0;
    tick();
    br = 1;
    #2; total++;
    if ({state, bg} !== {3'(ST_MISS_D), 1'b0}) begin
      bad++; $display("FAIL dma_to_missd got=%0d/%b want=3/0", state, bg);
    end
    tick();
    d_miss = 0; d_ready = 1;
    #2; total++;
    if ({state, bg} !== {3'(ST_MISS_D), 1'b0}) begin
      bad++; $display("FAIL dma_pending got=%0d/%b want=3/0", state, bg);
    end
    tick();
    d_ready = 0;
    tick();
    br = 0;
    #2; total++;
    if ({state, bg} !== {3'(ST_DMA_GRANT), 1'b1}) begin
      bad++; $display("FAIL dma_regrant got=%0d/%b want=5/1", state, bg);
    end
    tick();
`else
    for (int i = 0; i < 6; i++) begin
      br = 1;
      #2; total++;
      if ({state, bg, stage_we} !== {3'(ST_IDLE), 1'b0, 5'b11111}) begin
        bad++; $display("FAIL br_ignored i=%0d got=%0d/%b/%b want=0/0/11111", i, state, bg, stage_we);
      end
      tick();
    end
`endif
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    int m, nxt, glen, ea, eb;
    bit gi, gd, hz;
    logic [4:0] ewe;
    logic ef, eba, ebg;
    do_reset();
    m = M_IDLE; glen = 0; gi = 0; gd = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rs_id = AW'($urandom); rt_id = AW'($urandom);
      use_rs = 1'($urandom); use_rt = 1'($urandom);
      dest = (NF*AW)'($urandom); regwrite = NF'($urandom);
      load_ex = ($urandom_range(3) == 0);
      i_miss  = ($urandom_range(7) == 0);
      d_miss  = ($urandom_range(7) == 0);
      i_ready = ($urandom_range(3) == 0);
      d_ready = ($urandom_range(3) == 0);
      br      = ($urandom_range(2) != 0);
      halt_id = 0;
      #2;
      ea = ref_fwd(use_rs, rs_id, dest, regwrite);
      eb = ref_fwd(use_rt, rt_id, dest, regwrite);
      hz = load_ex && (ea == 1 || eb == 1);
      ewe = 5'b11111; ef = 0; eba = 0; ebg = (m == M_DG); nxt = m;
      case (m)
        M_IDLE: begin
          if (d_miss)              nxt = M_MD;
          else if (hz)             nxt = M_LS;
          else if (i_miss)         nxt = M_MI;
          else if (DMA_ON && br)   nxt = M_DG;
          if (nxt == M_LS) begin ewe = 5'b00011; ef = 1; end
          if (nxt == M_MI) begin ewe = 5'b00111; ef = 1; end
          if (nxt == M_MD) ewe = 5'b00000;
        end
        M_LS: begin ewe = d_miss ? 5'b00000 : 5'b11111; nxt = d_miss ? M_MD : M_IDLE; end
        M_MI: begin
          ewe = 5'b00111; ef = 1;
          if (d_miss) nxt = i_ready ? M_MD : M_MB; else if (i_ready) nxt = M_IDLE;
        end
        M_MD: begin
          ewe = 5'b00000;
          if (i_miss) nxt = d_ready ? M_MI : M_MB; else if (d_ready) nxt = M_IDLE;
        end
        M_MB: begin
          ewe = 5'b00000; eba = 1;
          if ((gi || i_ready) && (gd || d_ready)) nxt = M_IDLE;
        end
        M_DG: begin
          ewe = (i_miss || d_miss) ? 5'b00000 : 5'b11111;
          if (!br || glen + 1 == DL) nxt = d_miss ? M_MD : (i_miss ? M_MI : M_IDLE);
        end
        default: nxt = M_IDLE;
      endcase
      total++;
      if ({state, stage_we, flush_ex, both_access, bg, halted, fwd_a, fwd_b} !==
          {mode_code(m), ewe, ef, eba, ebg, 1'b0, SW'(ea), SW'(eb)}) begin
        bad++;
        $display("FAIL rand cyc=%0d got={st=%0d we=%b fl=%b ba=%b bg=%b h=%b fa=%0d fb=%0d} want={%0d %b %b %b %b 0 %0d %0d}",
                 cyc, state, stage_we, flush_ex, both_access, bg, halted, fwd_a, fwd_b,
                 mode_code(m), ewe, ef, eba, ebg, ea, eb);
      end
      if (m == M_MB && nxt == M_MB) begin gi = gi | i_ready; gd = gd | d_ready; end
      else begin gi = 0; gd = 0; end
      glen = (m == M_DG && nxt == M_DG) ? glen + 1 : 0;
      m = nxt;
      tick();
    end
    do_reset();
  endtask

  task automatic test_halt();
    clear_inputs();
    halt_id = 1;
    #2; total++;
    if ({stage_we, halted} !== {5'b00111, 1'b0}) begin
      bad++; $display("FAIL halt_entry got=%b/%b want=00111/0", stage_we, halted);
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      halt_id = 0;
      #2; total++;
      if ({state, stage_we, halted} !== {3'(ST_HALT), 5'b00111, (i > NF + 1)}) begin
        bad++; $display("FAIL halt_cycle i=%0d got=%0d/%b/%b want=6/00111/%b", i, state, stage_we, halted, (i > NF + 1));
      end
    end
  endtask

  task automatic test_reset_abort();
    reset_n = 0;
    #1; total++;
    if ({state, halted} !== {3'(ST_IDLE), 1'b0}) begin
      bad++; $display("FAIL abort_halt got=%0d/%b want=0/0", state, halted);
    end
    tick();
    reset_n = 1;
    d_miss = 1;
    tick(); tick();
    reset_n = 0;
    #1; total++;
    if ({state, stage_we, both_access} !== {3'(ST_IDLE), 5'b11111, 1'b0}) begin
      bad++; $display("FAIL abort_miss got=%0d/%b/%b want=0/11111/0", state, stage_we, both_access);
    end
    clear_inputs();
    tick();
    reset_n = 1;
`ifdef PIPE_STALL_CTRL_DMA_EN
    br = 1;
    tick(); tick(); tick();
    reset_n = 0;
    #1; total++;
    if ({state, bg, stage_we} !== {3'(ST_IDLE), 1'b0, 5'b11111}) begin
      bad++; $display("FAIL abort_dma got=%0d/%b/%b want=0/0/11111", state, bg, stage_we);
    end
    clear_inputs();
    tick();
    reset_n = 1;
`endif
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fwd_directed();
    test_fwd_random();
    test_load_use();
    test_dual_miss();
    test_dma();
    test_random();
    test_halt();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 2, register-address width.
REQ-002 SHALL have parameter NUM_FWD, default 3, number of forwarding stages (EX, MEM, WB, ...), range 1..7.
REQ-003 SHALL have parameter DMA_LEN, default 12, maximum bus-grant length in cycles, range 2..255.
REQ-004 SHALL have ports, in this order: clk  in  1  clock; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: rs_id, rt_id  in  REG_AW  ID source addresses; use_rs, use_rt  in  1  ID instruction reads rs/rt.
REQ-006 SHALL have ports: dest  in  NUM_FWD*REG_AW  destination per stage, slice k = stage k+1; regwrite  in  NUM_FWD  write enable per stage.
REQ-007 SHALL have ports: load_ex  in  1  load in EX; halt_id  in  1  halt in ID.
REQ-008 SHALL have ports: i_miss, d_miss  in  1  cache miss; i_ready, d_ready  in  1  one-cycle refill-done pulses.
REQ-009 SHALL have ports: br  in  1  DMA bus request; bg  out  1  bus grant (registered).
REQ-010 SHALL have ports: stage_we  out  5  {PC,ID,EX,M,WB} write enables; flush_ex  out  1  bubble into EX.
REQ-011 SHALL have ports: fwd_a, fwd_b  out  $clog2(NUM_FWD+1)  forward select, 0 = register file; both_access  out  1; halted  out  1; state  out  3  debug.

Function
REQ-012 fwd_a SHALL be the smallest k (1..NUM_FWD) with use_rs, regwrite[k-1] and dest slice k-1 == rs_id, else 0; fwd_b likewise with use_rt/rt_id; combinational.
REQ-013 Load-use hazard SHALL be load_ex and fwd_a==1 or fwd_b==1.
REQ-014 States SHALL be IDLE, LOAD_STALL, MISS_I, MISS_D, MISS_BOTH, DMA_GRANT, HALT.
REQ-015 IDLE priority: d_miss -> MISS_D; hazard -> LOAD_STALL; i_miss -> MISS_I; br -> DMA_GRANT; halt_id -> HALT; else stay.
REQ-016 Outputs in IDLE with no transition SHALL be stage_we=11111, flush_ex=0; on the transition cycle the target state's outputs apply combinationally.
REQ-017 LOAD_STALL: stage_we=00011, flush_ex=1, exactly one cycle, then IDLE (MISS_D if d_miss).
REQ-018 MISS_I: stage_we=00111, flush_ex=1; d_miss -> MISS_BOTH; i_ready -> IDLE.
REQ-019 MISS_D: stage_we=00000; i_miss -> MISS_BOTH; d_ready -> IDLE.
REQ-020 MISS_BOTH: stage_we=00000, both_access=1; sticky flags latch i_ready/d_ready (non-simultaneous pulses accepted); exit to IDLE in the cycle both flags are set; flags clear on exit.
REQ-021 DMA_GRANT: bg=1 from next cycle; 8-bit counter counts grant cycles; CPU runs (11111) while no miss, stage_we=00000 on any miss; release when br drops or counter==DMA_LEN-1; next state MISS_D/MISS_I if a miss is pending, else IDLE.
REQ-022 br SHALL NOT be granted while any MISS_* state is active; it is held pending.
REQ-023 HALT: stage_we=00111; counter increments; halted=1 after NUM_FWD+1 cycles and stays until reset.
REQ-024 Undefined state encodings SHALL return to IDLE.

Reset
REQ-025 While reset_n low: state=IDLE, bg=0, halted=0, counters and sticky flags 0, stage_we=11111, flush_ex=0, both_access=0.
REQ-026 Reset mid-miss or mid-grant SHALL abort immediately; bg drops asynchronously.

Configuration
REQ-027 Macro PIPE_STALL_CTRL_DMA_EN: defined -> REQ-021/022 implemented; undefined -> bg tied 0, DMA_GRANT unreachable, br ignored.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the state encoding, stage_we bit indices and the 00000/00011/00111/11111 constants.
REQ-029 Sub-module fwd_select (parametrised priority match) SHALL be instantiated twice.

Verification
REQ-030 rs_id=2, dest stage1=2 and stage2=2, both regwrite -> fwd_a=1; regwrite[0]=0 -> fwd_a=2.
REQ-031 load_ex=1 with hazard -> one cycle stage_we=00011, flush_ex=1, then 11111.
REQ-032 i_miss then d_miss next cycle; i_ready at t+3, d_ready at t+6 -> MISS_BOTH held until t+6, both_access=1, IDLE at t+7.
REQ-033 DMA_EN, br held 20 cycles -> bg high 12 cycles then 0; d_miss during grant -> stage_we=00000.
REQ-034 halt_id with NUM_FWD=3 -> stage_we=00111, halted=1 after 4 cycles.
REQ-035 reset_n low during DMA_GRANT -> bg=0, state=IDLE, stage_we=11111 immediately.
